// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the CPU debug snapshot scanner.
package cpu_debug_pkg;

  // Frame walk order: header, PC, INST, registers, memory window.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_PCW      = 3'd2,
    ST_INSTW    = 3'd3,
    ST_REG_ADDR = 3'd4,
    ST_REG_TX   = 3'd5,
    ST_MEM_ADDR = 3'd6,
    ST_MEM_TX   = 3'd7
  } state_e;

  localparam logic [7:0] FRAME_HDR      = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         NUM_REGS       = 32;

  // Bytes in one frame: header + PC + INST + registers + memory words.
  function automatic int frame_len(input int mem_words);
    return 1 + 2 * BYTES_PER_WORD + (NUM_REGS + mem_words) * BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/word_byte_tx.sv
// Serialises one loaded 32-bit word as 4 bytes, MSB first.
// Handshake: a byte moves on a clock edge where valid_o && ready_i; while
// valid_o is high and ready_i low, data_o and last_o are held, and valid_o
// only drops after the 4th byte has moved.
module word_byte_tx
  import cpu_debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        last_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        last_o,
  output logic        done_o
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        lastw_q, lastw_d;
  logic        final_byte;

  assign final_byte = (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Load has priority so a new word can follow the 4th byte with no gap.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    lastw_d = lastw_q;
    if (load_i) begin
      shreg_d = word_i;
      cnt_d   = 2'd0;
      valid_d = 1'b1;
      lastw_d = last_i;
    end else if (valid_q && ready_i) begin
      shreg_d = {shreg_q[23:0], 8'h00};
      cnt_d   = cnt_q + 2'd1;
      if (final_byte) begin
        valid_d = 1'b0;
        lastw_d = 1'b0;
      end
    end
  end

  // Shift register and byte counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 32'd0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      lastw_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      lastw_q <= lastw_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = shreg_q[31:24];
  assign last_o  = valid_q && lastw_q && final_byte;
  assign done_o  = valid_q && ready_i && final_byte;

endmodule

// File: rtl/cpu_debug_scanner.sv
// Walks the CPU debug port on each start pulse and streams one snapshot
// frame (A5, PC, INST, R0..R31, memory window) as bytes.
// Handshake: a byte moves on a clock edge where out_valid && out_ready;
// out_data/out_last are stable while out_valid && !out_ready, and out_valid
// never drops without a transfer.
module cpu_debug_scanner
  import cpu_debug_pkg::*;
#(
  parameter int          MEM_WORDS = 8,
  parameter logic [31:0] MEM_BASE  = 32'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [4:0]  rf_idx_q, rf_idx_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [6:0]  mem_idx_q, mem_idx_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  logic        tx_load, tx_last_in, tx_valid, tx_last, tx_done;
  logic [31:0] tx_word;
  logic [7:0]  tx_data;

  // Next state, address walk and serialiser load control.
  always_comb begin
    state_d    = state_q;
    rf_idx_d   = rf_idx_q;
    mem_addr_d = mem_addr_q;
    mem_idx_d  = mem_idx_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    tx_load    = 1'b0;
    tx_word    = 32'd0;
    tx_last_in = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        pc_d    = cpu_pc;
        inst_d  = cpu_inst;
        state_d = ST_HDR;
      end
      ST_HDR: if (out_ready) begin
        tx_load = 1'b1;
        tx_word = pc_q;
        state_d = ST_PCW;
      end
      ST_PCW: if (tx_done) begin
        tx_load = 1'b1;
        tx_word = inst_q;
        state_d = ST_INSTW;
      end
      ST_INSTW: if (tx_done) state_d = ST_REG_ADDR;
      ST_REG_ADDR: begin
        tx_load = 1'b1;
        tx_word = rf_data;
        state_d = ST_REG_TX;
      end
      ST_REG_TX: if (tx_done) begin
        if (rf_idx_q == 5'(NUM_REGS - 1)) begin
          state_d = ST_MEM_ADDR;
        end else begin
          rf_idx_d = rf_idx_q + 5'd1;
          state_d  = ST_REG_ADDR;
        end
      end
      ST_MEM_ADDR: begin
        tx_load    = 1'b1;
        tx_word    = mem_data;
        tx_last_in = (mem_idx_q == 7'(MEM_WORDS - 1));
        state_d    = ST_MEM_TX;
      end
      ST_MEM_TX: if (tx_done) begin
        if (mem_idx_q == 7'(MEM_WORDS - 1)) begin
          rf_idx_d   = 5'd0;
          mem_addr_d = MEM_BASE;
          mem_idx_d  = 7'd0;
          state_d    = ST_IDLE;
        end else begin
          mem_idx_d  = mem_idx_q + 7'd1;
          mem_addr_d = mem_addr_q + 32'd4;
          state_d    = ST_MEM_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, address counters and PC/INST snapshot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rf_idx_q   <= 5'd0;
      mem_addr_q <= MEM_BASE;
      mem_idx_q  <= 7'd0;
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      rf_idx_q   <= rf_idx_d;
      mem_addr_q <= mem_addr_d;
      mem_idx_q  <= mem_idx_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  word_byte_tx u_tx (
    .clk     (clk),
    .rst_n   (resetn),
    .load_i  (tx_load),
    .word_i  (tx_word),
    .last_i  (tx_last_in),
    .ready_i (out_ready),
    .valid_o (tx_valid),
    .data_o  (tx_data),
    .last_o  (tx_last),
    .done_o  (tx_done)
  );

  // The header byte comes straight from the FSM; everything else from u_tx.
  assign out_valid = (state_q == ST_HDR) || tx_valid;
  assign out_data  = (state_q == ST_HDR) ? FRAME_HDR : tx_data;
  assign out_last  = tx_last;
  assign busy      = (state_q != ST_IDLE);
  assign rf_addr   = rf_idx_q;
  assign mem_addr  = mem_addr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/cpu_debug_scanner.md
Name: cpu_debug_scanner

Overview:
- Downstream consumer of the single-cycle CPU's debug port. The CPU exposes `rf_addr`/`rf_data`, `mem_addr`/`mem_data`, `cpu_pc` and `cpu_inst`.
- On each `start` pulse the block walks all 32 registers and a window of data memory, then serialises one snapshot frame as a byte stream with a valid/ready handshake.
- The stream feeds the board UART/LCD path.

Parameters:
- MEM_WORDS, 8: number of 32-bit memory words dumped per frame; legal range 1..64.
- MEM_BASE, 32'd0: byte address of the first dumped word; must be word-aligned.

Ports:
- clk  input  1  system clock, shared with the CPU.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to emit a frame.
- rf_addr  output  5  register index driven to the CPU debug read port.
- mem_addr  output  32  byte address driven to the CPU debug memory port.
- rf_data  input  32  CPU register read data; asynchronous, valid in the same cycle as `rf_addr`.
- mem_data  input  32  CPU memory read data; asynchronous, valid in the same cycle as `mem_addr`.
- cpu_pc  input  32  current CPU PC.
- cpu_inst  input  32  current CPU instruction.
- out_valid  output  1  `out_data` holds a valid byte.
- out_ready  input  1  sink accepts the byte.
- out_data  output  8  frame byte.
- out_last  output  1  marks the final byte of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset state (asynchronous, on resetn=0): state IDLE, rf_addr=0, mem_addr=MEM_BASE, out_valid=0, out_data=0, out_last=0, busy=0.
- Frame format, in order:
  - header 8'hA5;
  - PC as 4 bytes, MSB first;
  - INST as 4 bytes, MSB first;
  - R0..R31, 4 bytes each, MSB first;
  - MEM_WORDS words starting at MEM_BASE with address stride 4, 4 bytes each, MSB first.
  - Total length = 137 + 4*MEM_WORDS bytes (169 at default).
- States: IDLE -> HDR -> PCW -> INSTW -> REG_ADDR -> REG_TX -> MEM_ADDR -> MEM_TX -> IDLE.
- IDLE:
  - start=1 at edge t captures cpu_pc and cpu_inst into snapshot registers in the same edge.
  - busy=1, out_valid=1, out_data=8'hA5 from cycle t+1.
  - start is ignored in every state other than IDLE.
- Transfer rule: a byte transfers on an edge where out_valid&&out_ready. While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops without a transfer.
- PCW/INSTW: shift the snapshot word out MSB first, one byte per transfer.
- REG_ADDR:
  - drive rf_addr=i (i = 0..31) for one cycle, with out_valid=0.
  - at the end of that cycle, latch rf_data into the 32-bit shift register.
  - REG_TX then sends 4 bytes; on the 4th transfer, i+1 goes to REG_ADDR, or after i=31 to MEM_ADDR.
  - Cost: one bubble cycle per word.
- MEM_ADDR/MEM_TX: same scheme with mem_addr = MEM_BASE + 4*j, for j = 0..MEM_WORDS-1.
- End of frame:
  - out_last=1 exactly while the final byte (LSB of the last memory word) is presented.
  - After that byte transfers: state IDLE, busy=0, out_valid=0, rf_addr=0, mem_addr=MEM_BASE.
- Address behaviour: rf_addr and mem_addr hold their last value outside the ADDR states. mem_addr arithmetic is 32-bit and wraps modulo 2^32 with no error.
- Snapshot consistency:
  - PC and INST are atomic to the start edge.
  - Register and memory values reflect the CPU state at their own read cycle; the CPU keeps running and mid-frame changes are not detected.
- A new frame can start on the first edge after the last transfer, i.e. busy=0 for a minimum of 1 cycle.
- Reset mid-frame: immediate return to reset values with no partial-frame completion. The sink must discard any frame missing out_last.

Decomposition:
- Package `cpu_debug_pkg`:
  - state enum/encoding;
  - FRAME_HDR=8'hA5;
  - BYTES_PER_WORD=4;
  - NUM_REGS=32;
  - frame-length function of MEM_WORDS.
- Sub-module `word_byte_tx`:
  - loads a 32-bit word and emits 4 bytes MSB first under valid/ready;
  - asserts `done` on the 4th transfer;
  - the `last` flag is passed through for the final byte.

Test Plan:
1. Reset; out_ready=1 held; CPU stub with rf_data=32'h1000_0000+rf_addr, mem_data=~mem_addr, cpu_pc=32'h0000_0040, cpu_inst=32'h2402_0005; pulse start.
   - Expect 169 bytes: A5, 00 00 00 40, 24 02 00 05, R0=10 00 00 00 … R31=10 00 00 1F, mem word0=FF FF FF FF.
   - out_last only on byte 169; busy falls the cycle after.
2. Same stimulus with out_ready driven by a random 30% duty pattern.
   - Byte sequence identical to test 1; out_data and out_last never change while valid&&!ready.
3. Pulse start again at bytes 5 and 100 of an active frame.
   - Exactly one frame emitted; no restart.
4. Assert resetn=0 asynchronously while register R10 is being sent.
   - out_valid, busy and rf_addr go to 0 before the next clock edge.
   - A following start yields a complete, fresh 169-byte frame.
5. cpu_pc changes from 32'h40 to 32'h44 one cycle after start.
   - Frame PC bytes read 00 00 00 40.
6. Parameters MEM_WORDS=1, MEM_BASE=32'hFFFF_FFFC.
   - mem_addr=FFFF_FFFC is driven once; frame is 141 bytes; mem_addr returns to FFFF_FFFC at idle.
